i2c_bus_monitor: RTL and testbench

//  Sequencing/control block that sits behind the SCL/SDA deglitch filters.

---
 rtl/i2c_bus_monitor_pkg.sv | 15 +
 rtl/i2c_bus_monitor_if.sv | 35 +++
 rtl/i2c_deglitch.sv | 39 +++
 rtl/i2c_bus_monitor.sv | 134 +++++++++++++
 tb/tb_i2c_bus_monitor.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_bus_monitor_pkg.sv
// Shared types and constants for the I2C bus monitor: framing FSM states,
// byte geometry and the idle level of the bus lines.
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BITS,
    ACK
  } state_e;

  localparam int   BYTE_BITS  = 8;
  localparam int   BIT_CNT_W  = $clog2(BYTE_BITS);
  localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bus-side bundle of the monitor: raw SCL/SDA in, filtered lines and
// decoded bus events out.
interface i2c_bus_monitor_if;
  import i2c_mon_pkg::*;

  // Event outputs are single-cycle strobes without back-pressure: a consumer
  // samples them in the cycle they are high. byte_o/ack_o hold until the next
  // strobe of byte_valid_o/ack_valid_o; busy_o and tmo_o are levels.
  logic                 scl_i;
  logic                 sda_i;
  logic                 scl_f_o;
  logic                 sda_f_o;
  logic                 start_o;
  logic                 rstart_o;
  logic                 stop_o;
  logic                 busy_o;
  logic                 byte_valid_o;
  logic [BYTE_BITS-1:0] byte_o;
  logic                 ack_valid_o;
  logic                 ack_o;
  logic                 tmo_o;

  modport master (
    output scl_i, sda_i,
    input  scl_f_o, sda_f_o, start_o, rstart_o, stop_o, busy_o,
    input  byte_valid_o, byte_o, ack_valid_o, ack_o, tmo_o
  );

  modport slave (
    input  scl_i, sda_i,
    output scl_f_o, sda_f_o, start_o, rstart_o, stop_o, busy_o,
    output byte_valid_o, byte_o, ack_valid_o, ack_o, tmo_o
  );

endinterface

// File: rtl/i2c_deglitch.sv
// Single-line stability filter: q_o follows d_i only after d_i has held a new
// value for max(thr,1) consecutive clocks.
module i2c_deglitch
  import i2c_mon_pkg::*;
#(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FILT_W-1:0] thr,
  input  logic              d_i,
  output logic              q_o
);

  logic [FILT_W-1:0] cnt;
  logic [FILT_W:0]   cnt_nxt;
  logic [FILT_W:0]   thr_eff;

  // One extra bit so cnt+1 never wraps; >= lets a lowered threshold release at once.
  always_comb begin
    cnt_nxt = {1'b0, cnt} + (FILT_W+1)'(1);
    thr_eff = (thr == '0) ? (FILT_W+1)'(1) : {1'b0, thr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= LINE_IDLE;
      cnt <= '0;
    end else if (d_i == q_o) begin
      cnt <= '0;
    end else if (cnt_nxt >= thr_eff) begin
      q_o <= d_i;
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt[FILT_W-1:0];
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, decodes START/repeated START/STOP,
// frames bits into bytes plus ACK, and flags SCL held low too long.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int FILT_W = 4,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FILT_W-1:0] filt_cycles_i,
  input  logic [TMO_W-1:0]  tmo_cycles_i,
  input  logic              clr_tmo_i,
  i2c_bus_monitor_if.slave  bus,
  output state_e            state_o
);

  logic                 scl_f, sda_f, scl_prev, sda_prev;
  logic                 scl_rise, start_det, stop_det, tmo_hit;
  logic [TMO_W-1:0]     tmo_cnt, tmo_inc;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_BITS-2:0] shreg;
  logic [BYTE_BITS-1:0] shift_nxt, byte_q;
  logic                 start_q, rstart_q, stop_q, busy_q;
  logic                 bv_q, av_q, ack_q, tmo_q;
  state_e               state;

  i2c_deglitch #(.FILT_W(FILT_W)) u_scl_filt (
    .clk(clk), .rst(rst), .thr(filt_cycles_i), .d_i(bus.scl_i), .q_o(scl_f)
  );

  i2c_deglitch #(.FILT_W(FILT_W)) u_sda_filt (
    .clk(clk), .rst(rst), .thr(filt_cycles_i), .d_i(bus.sda_i), .q_o(sda_f)
  );

  // Conditions need SCL high on both samples, so an SCL edge always wins over
  // a simultaneous SDA edge.
  always_comb begin
    scl_rise  = !scl_prev && scl_f;
    start_det = scl_prev && scl_f && sda_prev && !sda_f;
    stop_det  = scl_prev && scl_f && !sda_prev && sda_f;
    tmo_inc   = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    tmo_hit   = busy_q && !scl_f && (tmo_cycles_i != '0) && (tmo_inc >= tmo_cycles_i);
    shift_nxt = {shreg, sda_f};
  end

  // Edge history keeps tracking while disabled so re-enabling cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev <= LINE_IDLE;
      sda_prev <= LINE_IDLE;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_q   <= '0;
      tmo_cnt  <= '0;
      start_q  <= 1'b0;
      rstart_q <= 1'b0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
      bv_q     <= 1'b0;
      av_q     <= 1'b0;
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      start_q  <= start_det && !busy_q;
      rstart_q <= start_det && busy_q;
      stop_q   <= stop_det;
      bv_q     <= 1'b0;
      av_q     <= 1'b0;

      if (start_det)                busy_q <= 1'b1;
      else if (stop_det || tmo_hit) busy_q <= 1'b0;

      if (!busy_q || scl_f || tmo_hit) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_inc;

      if (tmo_hit)                                   tmo_q <= 1'b1;
      else if (clr_tmo_i || (start_det && !busy_q))  tmo_q <= 1'b0;

      if (start_det) begin
        state   <= BITS;
        bit_cnt <= '0;
      end else if (stop_det || tmo_hit) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          BITS: begin
            shreg <= shift_nxt[BYTE_BITS-2:0];
            if (bit_cnt == BIT_CNT_W'(BYTE_BITS-1)) begin
              bv_q    <= 1'b1;
              byte_q  <= shift_nxt;
              state   <= ACK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
          ACK: begin
            av_q    <= 1'b1;
            ack_q   <= sda_f;
            state   <= BITS;
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.scl_f_o      = en ? scl_f : LINE_IDLE;
  assign bus.sda_f_o      = en ? sda_f : LINE_IDLE;
  assign bus.start_o      = start_q;
  assign bus.rstart_o     = rstart_q;
  assign bus.stop_o       = stop_q;
  assign bus.busy_o       = busy_q;
  assign bus.byte_valid_o = bv_q;
  assign bus.byte_o       = byte_q;
  assign bus.ack_valid_o  = av_q;
  assign bus.ack_o        = ack_q;
  assign bus.tmo_o        = tmo_q;
  assign state_o          = state;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: filter timing, START/STOP decode, byte and
// ACK framing through a scoreboard, repeated START, timeout, reset and disable.
module tb_i2c_bus_monitor;
  import i2c_mon_pkg::*;

  localparam int FILT_W = 4;
  localparam int TMO_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b1;
  logic [FILT_W-1:0] filt = 4'd3;
  logic [TMO_W-1:0]  tmo  = '0;
  logic              clr_tmo = 1'b0;
  state_e            state;

  i2c_bus_monitor_if bus ();

  i2c_bus_monitor #(.FILT_W(FILT_W), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .filt_cycles_i(filt),
    .tmo_cycles_i (tmo),
    .clr_tmo_i    (clr_tmo),
    .bus          (bus),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [0:0] exp_ack_q[$];
  int start_cnt = 0, rstart_cnt = 0, stop_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every byte/ack strobe must match the head of its queue.
  always @(negedge clk) begin
    if (bus.start_o)  start_cnt++;
    if (bus.rstart_o) rstart_cnt++;
    if (bus.stop_o)   stop_cnt++;
    if (bus.byte_valid_o) begin
      if (exp_q.size() == 0) check("byte_unexpected", 32'(bus.byte_valid_o), 32'd0);
      else                   check("byte", 32'(bus.byte_o), 32'(exp_q.pop_front()));
    end
    if (bus.ack_valid_o) begin
      if (exp_ack_q.size() == 0) check("ack_unexpected", 32'(bus.ack_valid_o), 32'd0);
      else                       check("ack", 32'(bus.ack_o), 32'(exp_ack_q.pop_front()));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic d, input int n);
    bus.scl_i = s;
    bus.sda_i = d;
    wait_clk(n);
  endtask

  task automatic send_start();
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 4);
  endtask

  task automatic send_rstart();
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 4);
  endtask

  task automatic send_stop();
    drive(1'b0, 1'b0, 4);
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 6);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, b, 4);
    drive(1'b1, b, 6);
    drive(1'b0, b, 4);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic a);
    exp_q.push_back(v);
    exp_ack_q.push_back(a);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    send_bit(a);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".scl_f"}, 32'(bus.scl_f_o), 32'd1);
    check({tag, ".sda_f"}, 32'(bus.sda_f_o), 32'd1);
    check({tag, ".pulses"}, 32'({bus.start_o, bus.rstart_o, bus.stop_o,
                                 bus.byte_valid_o, bus.ack_valid_o}), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, ".tmo"}, 32'(bus.tmo_o), 32'd0);
    check({tag, ".byte"}, 32'(bus.byte_o), 32'd0);
    check({tag, ".state"}, 32'(state), 32'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int s0, r0, p0;
    logic [7:0] rnd;
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;

    // Reset
    wait_clk(3);
    check_idle("reset");
    rst = 1'b0;
    wait_clk(4);

    // 1. filt=3: 2-clk glitch ignored, 3-clk low passes at the 3rd edge
    s0 = start_cnt;
    bus.sda_i = 1'b0;
    wait_clk(2);
    bus.sda_i = 1'b1;
    @(negedge clk);
    check("glitch.sda_f", 32'(bus.sda_f_o), 32'd1);
    wait_clk(4);
    check("glitch.sda_f_later", 32'(bus.sda_f_o), 32'd1);
    check("glitch.no_start", 32'(start_cnt - s0), 32'd0);
    bus.sda_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("filt3.edge2", 32'(bus.sda_f_o), 32'd1);
    @(posedge clk); @(negedge clk);
    check("filt3.edge3", 32'(bus.sda_f_o), 32'd0);
    @(posedge clk); @(negedge clk);
    check("filt3.start", 32'(bus.start_o), 32'd1);
    wait_clk(4);
    p0 = stop_cnt;
    bus.sda_i = 1'b1;
    wait_clk(8);
    check("filt3.stop_cnt", 32'(stop_cnt - p0), 32'd1);
    check("filt3.busy", 32'(bus.busy_o), 32'd0);

    // 2. filt=2: START and STOP pulse timing
    filt = 4'd2;
    wait_clk(2);
    s0 = start_cnt;
    p0 = stop_cnt;
    bus.sda_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("start.early", 32'(bus.start_o), 32'd0);
    @(posedge clk); @(negedge clk);
    check("start.pulse", 32'(bus.start_o), 32'd1);
    check("start.busy", 32'(bus.busy_o), 32'd1);
    @(posedge clk); @(negedge clk);
    check("start.one_cycle", 32'(bus.start_o), 32'd0);
    wait_clk(4);
    bus.sda_i = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("stop.early", 32'(bus.stop_o), 32'd0);
    @(posedge clk); @(negedge clk);
    check("stop.pulse", 32'(bus.stop_o), 32'd1);
    check("stop.busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); @(negedge clk);
    check("stop.one_cycle", 32'(bus.stop_o), 32'd0);
    wait_clk(4);
    check("t2.start_cnt", 32'(start_cnt - s0), 32'd1);
    check("t2.stop_cnt", 32'(stop_cnt - p0), 32'd1);

    // 3. One byte 0xA5 with ACK
    send_start();
    send_byte(8'hA5, 1'b0);
    check("t3.state", 32'(state), 32'(BITS));
    check("t3.byte_hold", 32'(bus.byte_o), 32'hA5);
    send_stop();
    check("t3.busy", 32'(bus.busy_o), 32'd0);

    // 4. Partial byte dropped by repeated START, next byte intact
    send_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    r0 = rstart_cnt;
    s0 = start_cnt;
    send_rstart();
    check("t4.rstart", 32'(rstart_cnt - r0), 32'd1);
    check("t4.no_start", 32'(start_cnt - s0), 32'd0);
    check("t4.busy", 32'(bus.busy_o), 32'd1);
    send_byte(8'h3C, 1'b1);
    send_stop();

    // 5. SCL-low timeout
    tmo = 16'd100;
    send_start();
    wait_clk(80);
    check("tmo.before", 32'(bus.tmo_o), 32'd0);
    check("tmo.busy_before", 32'(bus.busy_o), 32'd1);
    wait_clk(40);
    check("tmo.set", 32'(bus.tmo_o), 32'd1);
    check("tmo.busy", 32'(bus.busy_o), 32'd0);
    check("tmo.state", 32'(state), 32'(IDLE));
    clr_tmo = 1'b1;
    wait_clk(1);
    clr_tmo = 1'b0;
    check("tmo.clr", 32'(bus.tmo_o), 32'd0);
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 6);
    tmo = '0;
    send_start();
    wait_clk(150);
    check("tmo0.flag", 32'(bus.tmo_o), 32'd0);
    check("tmo0.busy", 32'(bus.busy_o), 32'd1);
    send_stop();
    check("tmo0.busy_after", 32'(bus.busy_o), 32'd0);

    // 6a. Reset mid-byte
    send_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check_idle("rst_mid");
    for (int i = 0; i < 5; i++) send_bit(1'(i));
    send_stop();
    check("rst_mid.busy_after", 32'(bus.busy_o), 32'd0);

    // 6b. Disable during traffic
    send_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    en = 1'b0;
    s0 = start_cnt + rstart_cnt + stop_cnt;
    wait_clk(1);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      check_idle($sformatf("dis%0d", i));
    end
    check("dis.no_pulses", 32'(start_cnt + rstart_cnt + stop_cnt - s0), 32'd0);
    en = 1'b1;
    send_bit(1'b0);
    send_stop();
    rnd = 8'($urandom_range(0, 255));
    send_start();
    send_byte(rnd, 1'($urandom_range(0, 1)));
    send_stop();

    wait_clk(4);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
